btn_debounce_n: RTL
===================

// Module: btn_debounce_n
// PURPOSE
//  Input side of the board front-panel interface: the display path drives outputs; this block conditions the inputs.
//  Synchronises N raw pushbuttons/switches, debounces each one, and emits a clean level plus one-clock press,
//  release and auto-repeat pulses. These drive count_n enables/resets and display-mode controls in the top wrapper.
// PARAMETERS
//  N_BTN        5        number of independent input channels
//  PRESCALE     100000   clk cycles per sample tick (>=2); 1 ms at 100 MHz
//  DB_TICKS     10       consecutive agreeing sample ticks needed to accept a new level (>=1)
//  REPEAT_DELAY 500      sample ticks held after press before the first repeat pulse (>=1)
//  REPEAT_RATE  100      sample ticks between later repeat pulses (>=1)
// PORTS
//  clk      in   1      system clock
//  rst      in   1      asynchronous, active-high reset
//  en       in   1      1 = run; 0 = freeze prescaler, FSMs and counters
//  btn_raw  in   N_BTN  raw asynchronous button/switch inputs
//  level    out  N_BTN  debounced level per channel
//  press    out  N_BTN  1-clk pulse when level goes 0->1
//  release  out  N_BTN  1-clk pulse when level goes 1->0
//  repeat   out  N_BTN  1-clk auto-repeat pulse while level stays 1
// BEHAVIOUR
//  - Reset: level, press, release and repeat = 0. Synchroniser flops = 0, prescaler = 0, all FSMs in REL, counters 0.
//    Reset asserted mid-debounce or mid-hold aborts the channel immediately; no pulse is issued on reset exit.
//  - Sync: 2-flop synchroniser per bit. sync = btn_raw delayed 2 clks.
//  - Prescaler: free-running, 0..PRESCALE-1. tick = 1 for exactly one clk when count == PRESCALE-1, then wraps to 0.
//  - Per-channel FSM; it evaluates only on tick cycles. cnt is a sample-tick counter wide enough for max(DB_TICKS, REPEAT_DELAY).
//    REL:    level=0. sync=1 -> ARM_P with cnt=1, except DB_TICKS==1 -> HELD directly.
//    ARM_P:  sync=0 -> REL, cnt=0 (bounce rejected). sync=1 -> cnt++.
//            When cnt reaches DB_TICKS -> HELD, level=1, press=1 on that clk, rep_cnt=0.
//    HELD:   level=1. rep_cnt++ each tick.
//            First repeat pulse when rep_cnt reaches REPEAT_DELAY, then every REPEAT_RATE ticks after that.
//            rep_cnt saturates and re-arms internally; it never wraps to an early pulse.
//            sync=0 -> ARM_R with cnt=1; rep_cnt freezes.
//    ARM_R:  sync=1 -> HELD, cnt=0, rep_cnt resumes.
//            When cnt reaches DB_TICKS -> REL, level=0, release=1 on that clk.
//  - press, release and repeat are registered and high for exactly 1 clk. level changes on the same clk as press/release.
//  - repeat is never asserted in the same clk as press or release.
//  - Latency, raw edge to press: 2 clks (sync) + up to PRESCALE*DB_TICKS clks. Channels are fully independent.
//    Simultaneous edges on several channels give same-cycle pulses.
//  - en=0: prescaler and all FSM/counter state hold, pulse outputs forced 0, level holds.
//    Synchroniser keeps running. Resuming en continues from the held state with no lost or duplicate pulses.
// STRUCTURE
//  - Package nexys_io_pkg: typedef enum logic [1:0] {REL, ARM_P, HELD, ARM_R} db_state_t;
//    plus the localparam width function for cnt/rep_cnt ($clog2-based).
//  - Sub-module debounce_ch: one channel (FSM, cnt, rep_cnt, pulse regs), inputs clk, rst, en, tick, sync_bit.
//  - Top: synchroniser, prescaler, generate loop of N_BTN debounce_ch instances.
// TESTING (PRESCALE=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=5)
//  1 Clean press on btn_raw[0] held 40 clks -> exactly one press[0] pulse, within 2+12 clks of the edge;
//    level[0]=1; other channels stay 0.
//  2 Bounce: btn_raw[1] high for 2 ticks, low 1 tick, repeated 4x, then steady high -> no press during bounce;
//    one press 3 ticks after the steady edge.
//  3 Hold btn_raw[2] 20 ticks -> press, then repeat at tick 5 after press, then at 7, 9, ..., 19 (8 pulses);
//    release 3 ticks after drop; 0 repeats after release.
//  4 Release bounce: drop btn_raw[3] 2 ticks then high again -> no release, level stays 1;
//    the repeat cadence continues without skip or duplicate.
//  5 Reset mid-ARM_P and mid-HELD -> all outputs 0 asynchronously; no pulse on deassert while btn_raw=0.
//    With btn_raw=1, a fresh press follows DB_TICKS ticks later.
//  6 en=0 for 30 clks during ARM_P on ch4 and during HELD on ch0 -> no pulses, counters frozen;
//    on en=1, press/repeat arrive exactly the remaining tick count later.

Source files
------------

// File: rtl/nexys_io_pkg.sv
// Shared types and sizing helpers for the front-panel input path.
// Debounce FSM states plus the counter width function.
package nexys_io_pkg;

  typedef enum logic [1:0] {
    REL,
    ARM_P,
    HELD,
    ARM_R
  } db_state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced input channel: FSM, agree counter, auto-repeat.
// Evaluates only on enabled sample ticks; pulses are 1 clk wide.
module debounce_ch
  import nexys_io_pkg::*;
#(
  parameter int DB_TICKS     = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick,
  input  logic sync_bit,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CW =
    cnt_width(DB_TICKS, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] DB_N = CW'(DB_TICKS);
  localparam logic [CW-1:0] DLY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE = CW'(REPEAT_RATE);
  localparam bit SINGLE = (DB_TICKS == 1);

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rep_cnt;
  logic          rep_first;

  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] rep_nx;
  logic [CW-1:0] rep_lim;

  assign cnt_nx  = cnt + ONE;
  assign rep_nx  = rep_cnt + ONE;
  assign rep_lim = rep_first ? DLY : RATE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REL;
      cnt       <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
      if (en && tick) begin
        unique case (state)
          REL: begin
            if (sync_bit) begin
              if (SINGLE) begin
                state     <= HELD;
                level     <= 1'b1;
                press     <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b1;
              end else begin
                state <= ARM_P;
                cnt   <= ONE;
              end
            end
          end
          ARM_P: begin
            if (!sync_bit) begin
              state <= REL;
              cnt   <= '0;
            end else if (cnt_nx == DB_N) begin
              state     <= HELD;
              cnt       <= '0;
              level     <= 1'b1;
              press     <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b1;
            end else begin
              cnt <= cnt_nx;
            end
          end
          HELD: begin
            if (!sync_bit) begin
              if (SINGLE) begin
                state <= REL;
                level <= 1'b0;
                rel   <= 1'b1;
              end else begin
                state <= ARM_R;
                cnt   <= ONE;
              end
            end else if (rep_nx == rep_lim) begin
              // restart the count so it can never wrap early
              rpt       <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
            end else begin
              rep_cnt <= rep_nx;
            end
          end
          ARM_R: begin
            if (sync_bit) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt_nx == DB_N) begin
              state <= REL;
              cnt   <= '0;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              cnt <= cnt_nx;
            end
          end
          default: state <= REL;
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_debounce_n.sv
// Front-panel input conditioning: sync, sample prescaler and
// one debounce channel per button.
module btn_debounce_n
  import nexys_io_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int PRESCALE     = 100000,
  parameter int DB_TICKS     = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] rpt
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [PW-1:0]    pre;
  logic             tick;

  assign tick = (pre == PMAX);

  // synchroniser ignores en so resume sees a settled input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DB_TICKS    (DB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .tick    (tick),
      .sync_bit(sync2[i]),
      .level   (level[i]),
      .press   (press[i]),
      .rel     (rel[i]),
      .rpt     (rpt[i])
    );
  end

endmodule
